// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Desc     : 8N1 UART receive path. Two-flop input synchroniser, mid-bit
//            sampling FSM, valid/ack hold handshake towards the memory map,
//            single-cycle framing-error and overrun pulses.
//            Optional macro UART_RX_FIFO_EN replaces the single holding
//            register with an RX_FIFO_DEPTH-entry receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_SPEED     = 100_000_000,
    parameter int BAUDRATE      = 115200,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_SPEED / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_meta;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic [2:0]       bit_idx;
    logic             bit_idx_clr;
    logic             shift_en;
    logic [7:0]       shreg;
    logic             done;
    logic             frame_err;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= rxd;
            rxs       <= sync_meta;
        end
    end

    // FSM state, bit-time counter, data shifter and framing-error pulse
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_clr ? '0 : cnt + 1'b1;
            rx_frame_err <= frame_err;
            if (bit_idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            // LSB arrives first, so new bits enter at the top and move down
            if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    // Next-state decode; the counter is cleared on every state entry and on
    // every in-state sample so each sample lands mid-bit
    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        bit_idx_clr = 1'b0;
        shift_en    = 1'b0;
        done        = 1'b0;
        frame_err   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_clr     = 1'b1;
                    bit_idx_clr = 1'b1;
                    // High at mid start bit means it was only a glitch
                    state_next  = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A break or stuck-low line must not look like a new start bit
                cnt_clr = 1'b1;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

`ifdef UART_RX_FIFO_EN
    localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

    logic [7:0] mem [RX_FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    // Extra pointer MSB distinguishes full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = !empty;
    assign rx_data  = mem[rd_ptr[AW-1:0]];
    assign pop      = rx_valid & rx_ack;
    // A pop in the same cycle frees the slot the push needs
    assign push     = done && (!full || pop);

    // FIFO storage, pointers and overrun pulse
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rx_overrun <= done && !push;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    logic unused_fifo_depth;

    // Depth only matters when the FIFO is built; tie it off here
    assign unused_fifo_depth = (RX_FIFO_DEPTH != 0);

    // Single holding register: accept when empty or being consumed this cycle
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Desc     : Directed self-checking bench for uart_rx at 10 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_SPEED = 1_000_000;
    localparam int BAUDRATE  = 100_000;
    localparam int CPB       = CLK_SPEED / BAUDRATE;

    logic       clk = 1'b0;
    logic       rstz;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx #(
        .CLK_SPEED     (CLK_SPEED),
        .BAUDRATE      (BAUDRATE),
        .RX_FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rstz         (rstz),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (rstz) begin
            if (rx_frame_err) fe_cnt++;
            if (rx_overrun)   ov_cnt++;
        end
    end

    // Hold rxd for one bit time; leaves the caller 1 ns after a rising edge
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rstz   = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++;
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rstz = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b valid=%b expected 0 0", rx_busy, rx_valid);
        end
    endtask

    task automatic test_single_byte();
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);   // 0x55 LSB first
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b expected 0", rx_valid); end
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL t1_busy_in_frame: got %b expected 1", rx_busy); end
        drive_bit(1'b1);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b expected 1", rx_valid); end
        checks++;
        if (rx_data !== 8'h55) begin errors++; $display("FAIL t1_data: got %h expected 55", rx_data); end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
            errors++; $display("FAIL t1_hold: valid=%b data=%h expected 1 55", rx_valid, rx_data);
        end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle: got %b expected 0", rx_busy); end
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL t1_consume: got %b expected 0", rx_valid); end
`ifndef UART_RX_FIFO_EN
        checks++;
        if (rx_data !== 8'h55) begin errors++; $display("FAIL t1_data_kept: got %h expected 55", rx_data); end
`endif
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL t1_flags: frame_err=%0d overrun=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_glitch();
        int  fe0;
        int  ov0;
        bool_loop: begin end
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL t2_busy_start: got %b expected 1", rx_busy); end
        rxd = 1'b1;
        checks++;
        begin
            int n;
            n = 0;
            while (rx_busy !== 1'b0 && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (rx_busy !== 1'b0) begin errors++; $display("FAIL t2_busy_return: got %b expected 0 within 8 cycles", rx_busy); end
        end
        repeat (CPB * 12) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL t2_no_output: valid=%b frame_err=%0d overrun=%0d expected 0 0 0",
                               rx_valid, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA3, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL t3_frame_err_pulse: got %0d expected 1", fe_cnt - fe0); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL t3_no_valid: got %b expected 0", rx_valid); end
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL t3_wait_high_busy: got %b expected 1", rx_busy); end
        drive_bit(1'b1);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL t3_idle_after_high: got %b expected 0", rx_busy); end
        send_byte(8'h3C, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            errors++; $display("FAIL t3_next_byte: valid=%b data=%h expected 1 3c", rx_valid, rx_data);
        end
        checks++;
        if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL t3_single_pulse: got %0d expected 1", fe_cnt - fe0); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL t4_first: valid=%b data=%h expected 1 11", rx_valid, rx_data);
        end
`ifdef UART_RX_FIFO_EN
        checks++;
        if (ov_cnt != ov0) begin errors++; $display("FAIL t4_overrun: got %0d expected 0", ov_cnt - ov0); end
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
            errors++; $display("FAIL t4_second: valid=%b data=%h expected 1 22", rx_valid, rx_data);
        end
        pulse_ack();
`else
        checks++;
        if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL t4_overrun: got %0d expected 1", ov_cnt - ov0); end
        pulse_ack();
`endif
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL t4_drained: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);                 // 0xF0 bits 0..3
        rxd = 1'b1;                                                  // bit 4
        repeat (CPB / 2) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL t5_busy_before: got %b expected 1", rx_busy); end
        rstz = 1'b0;
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_busy !== 1'b0 ||
            rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL t5_async_reset: valid=%b data=%h busy=%b fe=%b ov=%b expected all 0",
                               rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun);
        end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstz = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h96, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h96) begin
            errors++; $display("FAIL t5_after_reset: valid=%b data=%h expected 1 96", rx_valid, rx_data);
        end
        pulse_ack();
    endtask

    task automatic test_ack_on_completion();
        int ov0;
        ov0 = ov_cnt;
        send_byte(8'hC5, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hC5) begin
            errors++; $display("FAIL t6_first: valid=%b data=%h expected 1 c5", rx_valid, rx_data);
        end
        // 0x7E with rx_ack asserted in exactly the stop-sample cycle
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i == 0 || i == 7 ? 1'b0 : 1'b1);
        rxd = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
            errors++; $display("FAIL t6_second: valid=%b data=%h expected 1 7e", rx_valid, rx_data);
        end
        checks++;
        if (ov_cnt != ov0) begin errors++; $display("FAIL t6_overrun: got %0d expected 0", ov_cnt - ov0); end
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL t6_drained: got %b expected 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_ack_on_completion();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
